// File: rtl/return_addr_stack_if.sv
// return_addr_stack_if: decode-side push/pop requests and the prediction returned to fetch.
interface return_addr_stack_if #(
   parameter int PC_WIDTH = 32,
   parameter int DEPTH    = 8
);
   localparam int PTR_W = $clog2(DEPTH);
   logic                ras_i_stall;
   logic                ras_i_flush;
   logic                ras_i_push;
   logic [PC_WIDTH-1:0] ras_i_push_ra;
   logic                ras_i_pop;
   logic [PC_WIDTH-1:0] ras_o_pred_pc;
   logic                ras_o_change_pc;
   logic [PTR_W:0]      ras_o_count;
   logic                ras_o_overflow;
   logic                ras_o_underflow;
   modport master (
      output ras_i_stall, ras_i_flush, ras_i_push, ras_i_push_ra, ras_i_pop,
      input  ras_o_pred_pc, ras_o_change_pc, ras_o_count, ras_o_overflow, ras_o_underflow
   );
   modport slave (
      input  ras_i_stall, ras_i_flush, ras_i_push, ras_i_push_ra, ras_i_pop,
      output ras_o_pred_pc, ras_o_change_pc, ras_o_count, ras_o_overflow, ras_o_underflow
   );
endinterface

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address predictor; JAL pushes pc+4, JR $ra pops and redirects fetch.
module return_addr_stack #(
   parameter int PC_WIDTH = 32,
   parameter int DEPTH    = 8
) (
   input logic                 ras_i_clk,
   input logic                 ras_i_rst,
   return_addr_stack_if.slave  ras_if
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
   logic [PC_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]    r_tp;
   logic [PTR_W:0]      r_cnt;
   logic                r_ovf;
   logic                r_unf;
   logic                w_empty;
   logic                w_full;
   logic [PTR_W-1:0]    w_tp_inc;
   logic [PTR_W-1:0]    w_tp_dec;
   assign w_empty  = (r_cnt == '0);
   assign w_full   = (r_cnt == FULL);
   assign w_tp_inc = r_tp + 1'b1;
   assign w_tp_dec = r_tp - 1'b1;
   assign ras_if.ras_o_pred_pc   = w_empty ? '0 : r_mem[r_tp];
   assign ras_if.ras_o_change_pc = ras_if.ras_i_pop & ~ras_if.ras_i_stall & ~ras_if.ras_i_flush & ~w_empty;
   assign ras_if.ras_o_count     = r_cnt;
   assign ras_if.ras_o_overflow  = r_ovf;
   assign ras_if.ras_o_underflow = r_unf;
   always_ff @(posedge ras_i_clk or negedge ras_i_rst) begin
      if (!ras_i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_tp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (ras_if.ras_i_flush) begin
         r_tp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (ras_if.ras_i_stall) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         // a same-cycle pop frees a slot first, so push+pop never overflows
         r_ovf <= ras_if.ras_i_push & ~ras_if.ras_i_pop & w_full;
         r_unf <= ras_if.ras_i_pop & w_empty;
         if (ras_if.ras_i_push && ras_if.ras_i_pop && !w_empty) begin
            r_mem[r_tp] <= ras_if.ras_i_push_ra;
         end else if (ras_if.ras_i_push) begin
            r_tp           <= w_tp_inc;
            r_mem[w_tp_inc] <= ras_if.ras_i_push_ra;
            if (!w_full) r_cnt <= r_cnt + 1'b1;
         end else if (ras_if.ras_i_pop && !w_empty) begin
            r_tp  <= w_tp_dec;
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: directed and random push/pop/stall/flush traffic checked against a queue model.
module tb_return_addr_stack;
   localparam int DEPTH = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_miss = 0;
   logic [31:0] q[$];
   logic e_ovf = 1'b0;
   logic e_unf = 1'b0;
   always #5 clk = ~clk;
   return_addr_stack_if #(.PC_WIDTH(32), .DEPTH(DEPTH)) ifc ();
   return_addr_stack #(.PC_WIDTH(32), .DEPTH(DEPTH)) dut (
      .ras_i_clk (clk),
      .ras_i_rst (rst_n),
      .ras_if    (ifc.slave)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic st, input logic fl, input logic pu, input logic [31:0] ra, input logic po);
      ifc.ras_i_stall   = st;
      ifc.ras_i_flush   = fl;
      ifc.ras_i_push    = pu;
      ifc.ras_i_push_ra = ra;
      ifc.ras_i_pop     = po;
   endtask
   task automatic check_outputs(input string tag, input logic st, input logic fl, input logic po);
      chk({tag, ".count"}, 32'(ifc.ras_o_count), 32'(q.size()));
      chk({tag, ".pred"}, ifc.ras_o_pred_pc, q.size() != 0 ? q[$] : 32'h0);
      chk({tag, ".chg"}, 32'(ifc.ras_o_change_pc), 32'(po && !st && !fl && q.size() != 0));
      chk({tag, ".ovf"}, 32'(ifc.ras_o_overflow), 32'(e_ovf));
      chk({tag, ".unf"}, 32'(ifc.ras_o_underflow), 32'(e_unf));
   endtask
   // one clock: drive at negedge, check just after, advance model across the rising edge
   task automatic step(input string tag, input logic st, input logic fl, input logic pu, input logic [31:0] ra, input logic po);
      drive(st, fl, pu, ra, po);
      #1;
      check_outputs(tag, st, fl, po);
      if (fl) begin
         q.delete();
         e_ovf = 1'b0;
         e_unf = 1'b0;
      end else if (st) begin
         e_ovf = 1'b0;
         e_unf = 1'b0;
      end else begin
         e_unf = po && q.size() == 0;
         e_ovf = pu && !po && q.size() == DEPTH;
         if (po && q.size() != 0) void'(q.pop_back());
         if (pu) begin
            q.push_back(ra);
            if (q.size() > DEPTH) void'(q.pop_front());
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   initial begin
      drive(0, 0, 0, 0, 0);
      // T1: reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
         #1;
         check_outputs("T1", 1'b1, 1'b1, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // T2
      step("T2", 0, 0, 1, 32'h100, 0);
      step("T2", 0, 0, 1, 32'h204, 0);
      step("T2", 0, 0, 1, 32'h308, 0);
      for (int i = 0; i < 4; i++) step("T2p", 0, 0, 0, 0, 1);
      // T3: overflow then drain and underflow
      for (int i = 1; i <= 9; i++) step("T3push", 0, 0, 1, 32'h1000 + 32'(i) * 4, 0);
      for (int i = 0; i < 9; i++) step("T3pop", 0, 0, 0, 0, 1);
      step("T3idle", 0, 0, 0, 0, 0);
      // T4: simultaneous push/pop, non-empty and empty
      step("T4", 0, 0, 1, 32'h20, 0);
      step("T4", 0, 0, 1, 32'h40, 0);
      step("T4pp", 0, 0, 1, 32'h80, 1);
      step("T4", 0, 0, 0, 0, 1);
      step("T4", 0, 0, 0, 0, 1);
      step("T4ppe", 0, 0, 1, 32'hC0, 1);
      step("T4", 0, 0, 0, 0, 0);
      // T5: stall freezes, flush drops push
      step("T5", 0, 0, 1, 32'h44, 0);
      step("T5st", 1, 0, 1, 32'h88, 1);
      step("T5st", 1, 0, 0, 0, 1);
      step("T5fl", 0, 1, 1, 32'h99, 0);
      step("T5", 0, 0, 0, 0, 0);
      // T6: asynchronous reset with five entries
      for (int i = 0; i < 5; i++) step("T6", 0, 0, 1, 32'h500 + 32'(i) * 4, 0);
      drive(0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      q.delete();
      e_ovf = 1'b0;
      e_unf = 1'b0;
      #1;
      check_outputs("T6rst", 1'b0, 1'b0, 1'b0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      // random traffic
      for (int i = 0; i < 400; i++)
         step("RND", $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
              1'($urandom), $urandom & 32'hFFFF_FFFC, 1'($urandom));
      step("END", 0, 0, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
